// File: rtl/spi_frame_loader_pkg.sv
// spi_frame_loader_pkg: shared LED chain defaults and frame-size helper for loader and serializer
package spi_frame_loader_pkg;
    localparam int DEF_LED_CNT       = 3;
    localparam int DEF_CHANNELS      = 3;
    localparam int DEF_BITPERCHANNEL = 8;

    function automatic int frame_bits(input int leds, input int channels, input int bits);
        return leds * channels * bits;
    endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-FF synchronizer with rise/fall detection against a third registered copy
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   sync       : synchronized level
//   rise, fall : one-cycle edge pulses on the synchronized level
module spi_sync #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [2:0] q;

    // Reset to the line's idle level so leaving reset never fakes an edge
    always_ff @(posedge clk)
        if (reset) q <= {3{INIT}};
        else       q <= {q[1:0], din};

    assign sync = q[1];
    assign rise = q[1] & ~q[2];
    assign fall = ~q[1] & q[2];
endmodule

// File: rtl/spi_frame_loader.sv
// spi_frame_loader: SPI mode-0 write-only receiver that commits whole frames atomically to data
//   clk, reset         : system clock, synchronous active-high reset
//   spi_sclk/mosi/cs_n : asynchronous SPI inputs
//   data               : committed frame, first wire bit in data[0]
//   frame_strobe       : one-cycle pulse when data updates
//   frame_error        : one-cycle pulse when a frame is discarded
//   busy               : high while receiving
module spi_frame_loader
    import spi_frame_loader_pkg::*;
#(
    parameter int LED_CNT       = DEF_LED_CNT,
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int BITPERCHANNEL = DEF_BITPERCHANNEL,
    parameter int DATAWIDTH     = frame_bits(LED_CNT, CHANNELS, BITPERCHANNEL)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    input  logic                 spi_cs_n,
    output logic [DATAWIDTH-1:0] data,
    output logic                 frame_strobe,
    output logic                 frame_error,
    output logic                 busy
);
    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATAWIDTH);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RECEIVE = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;

    logic [1:0]           state;
    logic [DATAWIDTH-1:0] shadow;
    logic [CW-1:0]        count;
    logic                 overrun;
    logic [1:0]           mosi_q;
    logic                 sclk_lvl, sclk_rise, sclk_fall;
    logic                 cs_lvl, cs_rise, cs_fall;
    logic                 unused;

    spi_sync #(.INIT(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .din(spi_sclk),
        .sync(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.INIT(1'b1)) u_cs (
        .clk(clk), .reset(reset), .din(spi_cs_n),
        .sync(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    assign unused = ^{sclk_lvl, sclk_fall, cs_lvl};
    assign busy   = state == RECEIVE;

    // MOSI has been stable for half an SCLK period, so its plain 2-FF copy aligns with sclk_rise
    always_ff @(posedge clk)
        if (reset) mosi_q <= '0;
        else       mosi_q <= {mosi_q[0], spi_mosi};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shadow       <= '0;
            count        <= '0;
            overrun      <= 1'b0;
            data         <= '0;
            frame_strobe <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                IDLE:
                    if (cs_fall) begin
                        count   <= '0;
                        overrun <= 1'b0;
                        state   <= RECEIVE;
                    end
                // cs_n release wins over a coincident sclk edge
                RECEIVE:
                    if (cs_rise) begin
                        if (count == FULL && !overrun) state <= COMMIT;
                        else begin
                            frame_error <= 1'b1;
                            state       <= IDLE;
                        end
                    end else if (sclk_rise) begin
                        if (count == FULL) overrun <= 1'b1;
                        else begin
                            shadow[count] <= mosi_q[1];
                            count         <= count + CW'(1);
                        end
                    end
                COMMIT: begin
                    data         <= shadow;
                    frame_strobe <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_loader.sv
// tb_spi_frame_loader: table-driven frame vectors plus hand-written multi-cycle sequences
module tb_spi_frame_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic [71:0] data;
    logic        frame_strobe, frame_error, busy;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int cs_cyc = 0;
    int strobe_cyc = 0;
    int n_strobe = 0;
    int n_error = 0;

    localparam logic [71:0] ONES = {72{1'b1}};

    typedef struct {
        string       name;
        int          nbits;
        logic [79:0] bytes;
        logic        exp_strobe;
        logic        exp_error;
        logic [71:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    spi_frame_loader dut (
        .clk(clk), .reset(reset),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .data(data), .frame_strobe(frame_strobe), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_strobe === 1'b1) begin
            n_strobe++;
            strobe_cyc = cyc;
        end
        if (frame_error === 1'b1) n_error++;
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Byte k sits at bytes[8k+7:8k] and goes out MSB first
    task automatic send_bits(input int nbits, input logic [79:0] bytes);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = bytes[8 * (i / 8) + 7 - (i % 8)];
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input int nbits, input logic [79:0] bytes, output logic busy_mid);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(nbits, bytes);
        repeat (4) @(negedge clk);
        busy_mid = busy;
        spi_cs_n = 1'b1;
        cs_cyc   = cyc;
    endtask

    initial begin
        int   s0, e0;
        logic bm;
        vecs[0] = '{"full_01",  72, 80'h01,   1'b1, 1'b0, 72'h80};
        vecs[1] = '{"full_ff",  72, {80{1'b1}}, 1'b1, 1'b0, ONES};
        vecs[2] = '{"short",    64, 80'h0,    1'b0, 1'b1, ONES};
        vecs[3] = '{"overrun",  80, 80'h0,    1'b0, 1'b1, ONES};
        vecs[4] = '{"partial",  71, 80'h0,    1'b0, 1'b1, ONES};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("reset_data", data, 72'h0);
        check("reset_busy", 72'(busy), 72'h0);
        check("reset_strobe", 72'(frame_strobe), 72'h0);
        check("reset_error", 72'(frame_error), 72'h0);
        check("reset_strobe_cnt", 72'(n_strobe), 72'h0);
        check("reset_error_cnt", 72'(n_error), 72'h0);

        for (int v = 0; v < 5; v++) begin
            s0 = n_strobe;
            e0 = n_error;
            frame(vecs[v].nbits, vecs[v].bytes, bm);
            repeat (10) @(negedge clk);
            check({vecs[v].name, "_busy_mid"}, 72'(bm), 72'h1);
            check({vecs[v].name, "_strobes"}, 72'(n_strobe - s0), 72'(vecs[v].exp_strobe));
            check({vecs[v].name, "_errors"}, 72'(n_error - e0), 72'(vecs[v].exp_error));
            check({vecs[v].name, "_data"}, data, vecs[v].exp_data);
            check({vecs[v].name, "_busy_end"}, 72'(busy), 72'h0);
            if (vecs[v].exp_strobe)
                check({vecs[v].name, "_latency"}, 72'(strobe_cyc - cs_cyc), 72'd4);
        end

        s0 = n_strobe;
        e0 = n_error;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(72, 80'h0);
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("b2b_first_data", data, 72'h0);
        frame(72, {80{1'b1}}, bm);
        repeat (10) @(negedge clk);
        check("b2b_strobes", 72'(n_strobe - s0), 72'd2);
        check("b2b_errors", 72'(n_error - e0), 72'd0);
        check("b2b_second_data", data, ONES);

        reset = 1'b1;
        @(negedge clk);
        check("reset_after_commit", data, 72'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        s0 = n_strobe;
        e0 = n_error;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(40, {10{8'hA5}});
        reset    = 1'b1;
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        frame(72, {10{8'hA5}}, bm);
        repeat (10) @(negedge clk);
        check("midreset_errors", 72'(n_error - e0), 72'd0);
        check("midreset_strobes", 72'(n_strobe - s0), 72'd1);
        check("midreset_data", data, {9{8'hA5}});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
